// File: rtl/id_stage_pipe.sv
// id_stage_pipe
//   Decode stage between IF and EX. Owns the integer register file, decodes
//   R / I-ALU / load / store / branch instructions, reads operands (with an
//   optional write-back bypass), builds the sign-extended immediate and
//   registers the result into the ID/EX stage behind a valid/ready handshake.
//   Inserts one bubble on a load-use hazard and blocks issue while a branch
//   is waiting for its outcome.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   if_valid / if_ready             IF -> ID handshake (if_ready is combinational)
//   if_instr, if_pc                 instruction word and its PC
//   wb_we, wb_addr, wb_data         register file write port
//   ex_valid / ex_ready             ID/EX -> EX handshake
//   ex_pc, ex_ctrl, ex_alu_op       registered PC, control byte, ALU op
//   ex_rs1_data, ex_rs2_data        registered operands
//   ex_rs1_addr, ex_rs2_addr        source register fields (for forwarding)
//   ex_rd_addr, ex_imm              destination register, immediate
//   br_resolve                      branch outcome known in EX
//   flush                           kill ID/EX contents and pending branch
//   illegal                         one-cycle pulse for an unknown opcode
module id_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [7:0]      ex_ctrl,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [AW-1:0]   ex_rs1_addr,
  output logic [AW-1:0]   ex_rs2_addr,
  output logic [AW-1:0]   ex_rd_addr,
  output logic [XLEN-1:0] ex_imm,
  input  logic            br_resolve,
  input  logic            flush,
  output logic            illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  localparam logic [7:0] CTRL_R  = 8'h22;
  localparam logic [7:0] CTRL_I  = 8'h32;
  localparam logic [7:0] CTRL_LD = 8'hF0;
  localparam logic [7:0] CTRL_ST = 8'h88;
  localparam logic [7:0] CTRL_BR = 8'h05;

  logic [XLEN-1:0] regs_r [NREGS];
  logic            br_pend_r;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [AW-1:0]   rs1_s;
  logic [AW-1:0]   rs2_s;
  logic [7:0]      dec_ctrl_s;
  logic [3:0]      dec_alu_op_s;
  logic [AW-1:0]   dec_rd_s;
  logic [XLEN-1:0] dec_imm_s;
  logic            dec_use_rs2_s;
  logic            dec_br_s;
  logic            dec_illegal_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;
  logic            hz_ld_s;
  logic            accept_s;

  assign opcode_s = if_instr[6:0];
  assign funct3_s = if_instr[14:12];
  assign rs1_s    = if_instr[15 +: AW];
  assign rs2_s    = if_instr[20 +: AW];

  // Instruction decode: control byte, ALU op, destination, immediate.
  always_comb begin
    dec_ctrl_s    = 8'h00;
    dec_alu_op_s  = 4'h0;
    dec_rd_s      = '0;
    dec_imm_s     = '0;
    dec_use_rs2_s = 1'b0;
    dec_br_s      = 1'b0;
    dec_illegal_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        dec_ctrl_s    = CTRL_R;
        dec_alu_op_s  = {if_instr[30], funct3_s};
        dec_rd_s      = if_instr[7 +: AW];
        dec_use_rs2_s = 1'b1;
      end
      OP_I: begin
        dec_ctrl_s = CTRL_I;
        // Only the right-shift encoding carries an op bit in instr[30] (SRAI).
        if (funct3_s == 3'b101) begin
          dec_alu_op_s = {if_instr[30], funct3_s};
        end else begin
          dec_alu_op_s = {1'b0, funct3_s};
        end
        dec_rd_s  = if_instr[7 +: AW];
        dec_imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
      OP_LD: begin
        dec_ctrl_s = CTRL_LD;
        dec_rd_s   = if_instr[7 +: AW];
        dec_imm_s  = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
      OP_ST: begin
        dec_ctrl_s    = CTRL_ST;
        dec_imm_s     = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        dec_use_rs2_s = 1'b1;
      end
      OP_BR: begin
        dec_ctrl_s    = CTRL_BR;
        dec_imm_s     = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
        dec_use_rs2_s = 1'b1;
        dec_br_s      = 1'b1;
      end
      OP_NOP: begin
        dec_ctrl_s = 8'h00;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Operand read; x0 is never written so it always reads zero, and the
  // bypass must not forward a (discarded) write to x0.
  always_comb begin
    rs1_data_s = regs_r[rs1_s];
    rs2_data_s = regs_r[rs2_s];
    if (BYPASS_EN && wb_we && (wb_addr == rs1_s) && (rs1_s != '0)) begin
      rs1_data_s = wb_data;
    end else begin
      rs1_data_s = regs_r[rs1_s];
    end
    if (BYPASS_EN && wb_we && (wb_addr == rs2_s) && (rs2_s != '0)) begin
      rs2_data_s = wb_data;
    end else begin
      rs2_data_s = regs_r[rs2_s];
    end
  end

  // Load-use hazard against the load sitting in ID/EX, and issue permission.
  always_comb begin
    hz_ld_s = 1'b0;
    if (ex_valid && (ex_ctrl == CTRL_LD) && (ex_rd_addr != '0)) begin
      hz_ld_s = (ex_rd_addr == rs1_s) || (dec_use_rs2_s && (ex_rd_addr == rs2_s));
    end else begin
      hz_ld_s = 1'b0;
    end
    if_ready = (!ex_valid || ex_ready) && !hz_ld_s && !br_pend_r && !flush;
    accept_s = if_valid && if_ready;
  end

  // Register file: reset to zero, writes to x0 dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_we && (wb_addr != '0)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Pending-branch flag: a resolve in the issue cycle means nothing to wait for.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_pend_r <= 1'b0;
    end else if (flush) begin
      br_pend_r <= 1'b0;
    end else if (accept_s && dec_br_s && !br_resolve) begin
      br_pend_r <= 1'b1;
    end else if (br_resolve) begin
      br_pend_r <= 1'b0;
    end
  end

  // ID/EX stage: load on accept, drop valid when drained, hold when stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_ctrl     <= 8'h00;
      ex_alu_op   <= 4'h0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      ex_imm      <= '0;
      illegal     <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      illegal <= accept_s && dec_illegal_s;
      if (accept_s) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_ctrl     <= dec_ctrl_s;
        ex_alu_op   <= dec_alu_op_s;
        ex_rs1_data <= rs1_data_s;
        ex_rs2_data <= rs2_data_s;
        ex_rs1_addr <= rs1_s;
        ex_rs2_addr <= rs2_s;
        ex_rd_addr  <= dec_rd_s;
        ex_imm      <= dec_imm_s;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
